// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and base types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs <= 1) ? 1 : $clog2(nregs);
    endfunction

    localparam int unsigned AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

    localparam reg_data_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_busy_sb.sv
// Per-register pending-write scoreboard: set on issue, clear on writeback, flush-all,
// plus a registered count of busy registers.
module regfile_busy_sb
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 1,
    parameter int unsigned AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NREGS-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    // Priority low to high: clear, set (newer producer), flush.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en && iss_rd != '0)
            busy_nxt[iss_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with same-cycle write bypass and a busy scoreboard
// for hazard stalls; x0 is hardwired to zero and never busy.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    ra;
    logic             hit;
    logic [XLEN-1:0]  val;

    // Ascending port order makes the highest-index writer win on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Reads are forced to zero during reset so bypassed write data cannot leak out.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        hit     = 1'b0;
        val     = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra  = rd_addr[k*AW +: AW];
            hit = 1'b0;
            val = regs[ra];
            for (int unsigned j = 0; j < NWR; j++) begin
                if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
                    hit = 1'b1;
                    val = wr_data[j*XLEN +: XLEN];
                end
            end
            if (rst_n && ra != '0) begin
                rd_data[k*XLEN +: XLEN] = val;
                rd_busy[k]              = busy[ra] & ~hit;
            end
        end
    end

    regfile_busy_sb #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_busy_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: bypass and non-bypass instances share one stimulus
// stream and are checked against an array-based reference model.
module tb_regfile_mp_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;

    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic [AW:0]         busy_cnt_b, busy_cnt_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_mp_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)
    ) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt_n)
    );

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        logic [XLEN-1:0] v;
        if (!rst_n || a == 0) return '0;
        v = m_reg[a];
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        bit written = 0;
        if (!rst_n || a == 0) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) written = 1;
        return m_busy[a] && !(byp && written);
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            check({tag, "/data_byp"},  64'(rd_data_b[k*XLEN +: XLEN]), 64'(exp_data(a, 1)));
            check({tag, "/data_nob"},  64'(rd_data_n[k*XLEN +: XLEN]), 64'(exp_data(a, 0)));
            check({tag, "/busy_byp"},  64'(rd_busy_b[k]), 64'(exp_busy(a, 1)));
            check({tag, "/busy_nob"},  64'(rd_busy_n[k]), 64'(exp_busy(a, 0)));
        end
        check({tag, "/cnt_byp"}, 64'(busy_cnt_b), 64'(busy_count()));
        check({tag, "/cnt_nob"}, 64'(busy_cnt_n), 64'(busy_count()));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 0;
        end
    endtask

    task automatic model_update();
        logic [AW-1:0] a;
        for (int j = 0; j < NWR; j++) begin
            a = wr_addr[j*AW +: AW];
            if (wr_en[j] && a != 0) begin
                m_reg[a]  = wr_data[j*XLEN +: XLEN];
                m_busy[a] = 0;
            end
        end
        if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1;
        if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    // Check combinational outputs mid-cycle, then advance the model with the clock edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic set_rd(input int p0, input int p1);
        rd_addr[0 +: AW]  = AW'(p0);
        rd_addr[AW +: AW] = AW'(p1);
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
        wr_en[j]              = 1'b1;
        wr_addr[j*AW +: AW]   = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic random_cycle(input string tag);
        for (int j = 0; j < NWR; j++) begin
            wr_en[j]                = 1'($urandom_range(0, 1));
            wr_addr[j*AW +: AW]     = AW'($urandom_range(0, 15));
            wr_data[j*XLEN +: XLEN] = $urandom;
        end
        for (int k = 0; k < NRD; k++)
            rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1)
                ? wr_addr[($urandom_range(0, NWR-1))*AW +: AW] : AW'($urandom_range(0, 31));
        iss_en = 1'($urandom_range(0, 1));
        iss_rd = AW'($urandom_range(0, 15));
        flush  = ($urandom_range(0, 15) == 0);
        cycle(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        model_reset();
        #22;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // x0 writes and issues are ignored
        set_wr(0, 0, 32'hDEADBEEF);
        iss_en = 1'b1; iss_rd = '0;
        set_rd(0, 0);
        cycle("x0_wr");
        idle();
        cycle("x0_after");

        // Bypass vs stored value on x5
        set_wr(0, 5, 32'h1234);
        set_rd(5, 0);
        cycle("byp_x5");
        idle();
        cycle("byp_x5_after");

        // Both ports write x7: port 1 wins
        set_wr(0, 7, 32'hA);
        set_wr(1, 7, 32'hB);
        set_rd(7, 7);
        cycle("dual_x7");
        idle();
        cycle("dual_x7_after");

        // Scoreboard set/clear priority
        iss_en = 1'b1; iss_rd = 5'd3;
        set_rd(3, 4);
        cycle("iss_x3");
        iss_rd = 5'd4;
        cycle("iss_x4");
        idle();
        cycle("busy_2");
        set_wr(0, 3, 32'h33);
        iss_en = 1'b1; iss_rd = 5'd3;
        cycle("wr_iss_x3");
        idle();
        cycle("x3_still_busy");
        set_wr(1, 4, 32'h44);
        cycle("wr_x4");
        idle();
        cycle("busy_1");

        // Flush overrides a same-cycle issue
        for (int r = 10; r < 15; r++) begin
            iss_en = 1'b1; iss_rd = AW'(r);
            set_rd(r, 9);
            cycle("iss_many");
        end
        idle();
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd9;
        set_wr(0, 20, 32'h2020);
        set_rd(9, 20);
        cycle("flush");
        idle();
        cycle("after_flush");

        for (int n = 0; n < 300; n++) random_cycle("rand");

        // Asynchronous reset mid-run, checked before any clock edge
        for (int j = 0; j < NWR; j++) set_wr(j, 6 + j, $urandom);
        set_rd(6, 7);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrun_reset");
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 200; n++) random_cycle("rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
